// File: rtl/rect_anim_seq_if.sv
// rect_anim_seq_if: rectangle draw request channel between the animator and rect_draw
interface rect_anim_seq_if;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [15:0] req_w;
  logic [15:0] req_h;
  logic [31:0] req_color;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_obj;
  modport master (output req_x, req_y, req_w, req_h, req_color, req_valid, req_obj, input req_ready);
  modport slave  (input req_x, req_y, req_w, req_h, req_color, req_valid, req_obj, output req_ready);
endinterface

// File: rtl/rect_anim_seq.sv
// rect_anim_seq: per-frame erase/move/draw sequencer for NUM_OBJS bouncing, hue-cycling rectangles
module rect_anim_seq #(
  parameter int unsigned NUM_OBJS = 4,
  parameter int unsigned SCREEN_W = 1920,
  parameter int unsigned SCREEN_H = 1080,
  parameter int unsigned RECT_W   = 200,
  parameter int unsigned RECT_H   = 200,
  parameter int unsigned STEP     = 1,
  parameter int unsigned HUE_STEP = 1,
  parameter int unsigned INIT_X0  = 100,
  parameter int unsigned INIT_Y0  = 100,
  parameter int unsigned SPACING  = 64,
  parameter int unsigned ERASE_EN = 1,
  parameter logic [31:0] BG_COLOR = 32'h0
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 enable,
  input  logic                 frame_tick,
  rect_anim_seq_if.master      rq,
  output logic                 busy,
  output logic [15:0]          overrun_cnt
);
  localparam int IW = NUM_OBJS > 1 ? $clog2(NUM_OBJS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_OBJS - 1);
  localparam logic [16:0] X_MAX = 17'(SCREEN_W - RECT_W);
  localparam logic [16:0] Y_MAX = 17'(SCREEN_H - RECT_H);
  localparam logic [15:0] ST = 16'(STEP);
  typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;
  state_t        state;
  logic [IW-1:0] idx, nidx;
  // dx/dy: 1 means moving towards 0
  logic [15:0]   x [2**IW];
  logic [15:0]   y [2**IW];
  logic          dx [2**IW];
  logic          dy [2**IW];
  logic [10:0]   hue [2**IW];
  logic [15:0]   cx, cy, nx, ny;
  logic [16:0]   xs, ys;
  logic          fx, fy, xfer;
  logic [11:0]   hs;
  logic [10:0]   nh;
  logic [2:0]    seg;
  logic [7:0]    lo, r, g, b;
  assign busy = state != IDLE;
  assign rq.req_w = 16'(RECT_W);
  assign rq.req_h = 16'(RECT_H);
  assign xfer = rq.req_valid & rq.req_ready;
  always_comb begin
    nidx = idx + 1'b1;
    cx = x[idx];
    cy = y[idx];
    xs = {1'b0, cx} + {1'b0, ST};
    ys = {1'b0, cy} + {1'b0, ST};
    fx = dx[idx] ? cx < ST : xs >= X_MAX;
    fy = dy[idx] ? cy < ST : ys >= Y_MAX;
    nx = dx[idx] ? (fx ? 16'd0 : cx - ST) : (fx ? X_MAX[15:0] : xs[15:0]);
    ny = dy[idx] ? (fy ? 16'd0 : cy - ST) : (fy ? Y_MAX[15:0] : ys[15:0]);
    hs = {1'b0, hue[idx]} + 12'(HUE_STEP);
    nh = hs >= 12'd1536 ? 11'(hs - 12'd1536) : hs[10:0];
    // each 256-wide hue segment ramps one channel up or down via the low byte
    seg = nh[10:8];
    lo = nh[7:0];
    r = (seg == 3'd0 || seg == 3'd5) ? 8'hFF : seg == 3'd1 ? ~lo : seg == 3'd4 ? lo : 8'h00;
    g = (seg == 3'd1 || seg == 3'd2) ? 8'hFF : seg == 3'd0 ? lo : seg == 3'd3 ? ~lo : 8'h00;
    b = (seg == 3'd3 || seg == 3'd4) ? 8'hFF : seg == 3'd2 ? lo : seg == 3'd5 ? ~lo : 8'h00;
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      idx <= '0;
      rq.req_valid <= 1'b0;
      rq.req_x <= '0;
      rq.req_y <= '0;
      rq.req_color <= '0;
      rq.req_obj <= '0;
      overrun_cnt <= '0;
      for (int i = 0; i < 2**IW; i++) begin
        x[i] <= 16'(INIT_X0 + i * SPACING);
        y[i] <= 16'(INIT_Y0 + i * SPACING);
        dx[i] <= 1'(i % 2);
        dy[i] <= 1'b0;
        hue[i] <= 11'((i * 256) % 1536);
      end
    end else begin
      if (frame_tick && state != IDLE && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
      case (state)
        IDLE: if (frame_tick && enable) begin
          idx <= '0;
          if (ERASE_EN != 0) begin
            state <= ERASE;
            rq.req_valid <= 1'b1;
            rq.req_x <= x[0];
            rq.req_y <= y[0];
            rq.req_color <= BG_COLOR;
            rq.req_obj <= '0;
          end else begin
            state <= UPDATE;
          end
        end
        ERASE: if (xfer) begin
          if (idx == LAST) begin
            idx <= '0;
            state <= UPDATE;
            rq.req_valid <= 1'b0;
          end else begin
            idx <= nidx;
            rq.req_x <= x[nidx];
            rq.req_y <= y[nidx];
            rq.req_obj <= 4'(nidx);
          end
        end
        UPDATE: begin
          x[idx] <= nx;
          y[idx] <= ny;
          dx[idx] <= dx[idx] ^ fx;
          dy[idx] <= dy[idx] ^ fy;
          hue[idx] <= nh;
          state <= DRAW;
          rq.req_valid <= 1'b1;
          rq.req_x <= nx;
          rq.req_y <= ny;
          rq.req_color <= {8'h00, b, g, r};
          rq.req_obj <= 4'(idx);
        end
        DRAW: if (xfer) begin
          rq.req_valid <= 1'b0;
          idx <= idx == LAST ? '0 : nidx;
          state <= idx == LAST ? IDLE : UPDATE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rect_anim_seq.sv
// tb_rect_anim_seq: directed checks of erase/draw sequencing, bounce, stall, hue wrap and reset
module tb_rect_anim_seq;
  logic clk = 1'b0;
  logic arst, en;
  logic tk [3];
  logic rdy [3];
  logic [15:0] ox [3], oy [3], ow [3], oh [3], ovr [3];
  logic [31:0] oc [3];
  logic [3:0] oo [3];
  logic ov [3], ob [3];
  logic [15:0] gx, gy, x0, x1;
  logic [31:0] gc, c0;
  logic [3:0] gob;
  logic [15:0] ex [4] = '{16'd101, 16'd163, 16'd229, 16'd291};
  logic [15:0] ey [4] = '{16'd101, 16'd165, 16'd229, 16'd293};
  logic [31:0] ec [4] = '{32'h000001FF, 32'h0000FFFE, 32'h0001FF00, 32'h00FFFE00};
  int checks = 0, passed = 0, fails = 0;
  rect_anim_seq_if ia();
  rect_anim_seq_if ic();
  rect_anim_seq_if id();
  always #5 clk = ~clk;
  rect_anim_seq u_a (.clk(clk), .arst(arst), .enable(en), .frame_tick(tk[0]), .rq(ia), .busy(ob[0]), .overrun_cnt(ovr[0]));
  rect_anim_seq #(.NUM_OBJS(2), .SCREEN_W(400), .SCREEN_H(400), .STEP(3), .INIT_X0(0), .INIT_Y0(0), .SPACING(2))
    u_c (.clk(clk), .arst(arst), .enable(en), .frame_tick(tk[1]), .rq(ic), .busy(ob[1]), .overrun_cnt(ovr[1]));
  rect_anim_seq #(.ERASE_EN(0))
    u_d (.clk(clk), .arst(arst), .enable(en), .frame_tick(tk[2]), .rq(id), .busy(ob[2]), .overrun_cnt(ovr[2]));
  assign ia.req_ready = rdy[0];
  assign ic.req_ready = rdy[1];
  assign id.req_ready = rdy[2];
  assign ox[0] = ia.req_x; assign oy[0] = ia.req_y; assign ow[0] = ia.req_w; assign oh[0] = ia.req_h;
  assign oc[0] = ia.req_color; assign oo[0] = ia.req_obj; assign ov[0] = ia.req_valid;
  assign ox[1] = ic.req_x; assign oy[1] = ic.req_y; assign ow[1] = ic.req_w; assign oh[1] = ic.req_h;
  assign oc[1] = ic.req_color; assign oo[1] = ic.req_obj; assign ov[1] = ic.req_valid;
  assign ox[2] = id.req_x; assign oy[2] = id.req_y; assign ow[2] = id.req_w; assign oh[2] = id.req_h;
  assign oc[2] = id.req_color; assign oo[2] = id.req_obj; assign ov[2] = id.req_valid;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // called at a negedge; returns at the negedge following the accepted request
  task automatic get(input int d);
    bit got = 1'b0;
    gx = '0; gy = '0; gc = '0; gob = '0;
    for (int n = 0; n < 100 && !got; n++) begin
      if (ov[d] && rdy[d]) begin
        gx = ox[d]; gy = oy[d]; gc = oc[d]; gob = oo[d]; got = 1'b1;
      end
      @(negedge clk);
    end
    chk("req_timeout", 64'(got), 64'd1);
  endtask

  task automatic tick(input int d);
    tk[d] = 1'b1;
    @(negedge clk);
    tk[d] = 1'b0;
  endtask

  initial begin
    arst = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin tk[i] = 1'b0; rdy[i] = 1'b1; end
    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(ov[0]), 0);
    chk("rst_busy", 64'(ob[0]), 0);
    chk("rst_overrun", 64'(ovr[0]), 0);
    chk("rst_w", 64'(ow[0]), 200);
    chk("rst_h", 64'(oh[0]), 200);
    chk("rst_x", 64'(ox[0]), 0);
    chk("rst_color", 64'(oc[0]), 0);
    chk("rst_obj", 64'(oo[0]), 0);
    // frame 1, defaults
    tick(0);
    chk("first_valid", 64'(ov[0]), 1);
    chk("busy_frame", 64'(ob[0]), 1);
    for (int i = 0; i < 4; i++) begin
      get(0);
      chk("erase_x", 64'(gx), 64'(100 + 64 * i));
      chk("erase_y", 64'(gy), 64'(100 + 64 * i));
      chk("erase_color", 64'(gc), 0);
      chk("erase_obj", 64'(gob), 64'(i));
    end
    for (int i = 0; i < 4; i++) begin
      get(0);
      chk("draw_x", 64'(gx), 64'(ex[i]));
      chk("draw_y", 64'(gy), 64'(ey[i]));
      chk("draw_color", 64'(gc), 64'(ec[i]));
      chk("draw_obj", 64'(gob), 64'(i));
    end
    chk("idle_busy", 64'(ob[0]), 0);
    chk("idle_valid", 64'(ov[0]), 0);
    // frame 2 with ready stalled during erase of obj2, plus a tick while busy
    tick(0);
    get(0);
    chk("f2_erase0_x", 64'(gx), 101);
    get(0);
    chk("f2_erase1_x", 64'(gx), 163);
    rdy[0] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tk[0] = (s == 1);
      @(negedge clk);
      chk("stall_valid", 64'(ov[0]), 1);
      chk("stall_x", 64'(ox[0]), 229);
      chk("stall_y", 64'(oy[0]), 229);
      chk("stall_obj", 64'(oo[0]), 2);
    end
    tk[0] = 1'b0;
    rdy[0] = 1'b1;
    get(0);
    chk("f2_erase2_x", 64'(gx), 229);
    get(0);
    chk("f2_erase3_y", 64'(gy), 293);
    get(0);
    chk("f2_draw0_x", 64'(gx), 102);
    chk("f2_draw0_color", 64'(gc), 32'h000002FF);
    repeat (3) get(0);
    repeat (10) @(negedge clk);
    chk("no_extra_frame_valid", 64'(ov[0]), 0);
    chk("no_extra_frame_busy", 64'(ob[0]), 0);
    chk("overrun_cnt", 64'(ovr[0]), 1);
    // wall bounces on the small screen
    for (int k = 1; k <= 68; k++) begin
      tick(1);
      get(1);
      get(1);
      if (k == 2) chk("wall_erase1_x", 64'(gx), 0);
      get(1); x0 = gx;
      get(1); x1 = gx;
      if (k == 1) begin chk("left_clamp_x", 64'(x1), 0); chk("obj0_k1_x", 64'(x0), 3); end
      if (k == 2) chk("left_bounce_x", 64'(x1), 3);
      if (k == 67) chk("right_clamp_x", 64'(x0), 200);
      if (k == 68) chk("right_bounce_x", 64'(x0), 197);
    end
    // draw-only variant and hue wrap
    tick(2);
    chk("noerase_no_erase_req", 64'(ov[2]), 0);
    get(2);
    chk("noerase_draw0_xy", {32'(gx), 32'(gy)}, {32'd101, 32'd101});
    chk("noerase_draw0_color", 64'(gc), 32'h000001FF);
    repeat (3) get(2);
    chk("noerase_last_obj", 64'(gob), 3);
    repeat (5) @(negedge clk);
    chk("noerase_count_valid", 64'(ov[2]), 0);
    chk("noerase_count_busy", 64'(ob[2]), 0);
    for (int k = 2; k <= 1537; k++) begin
      tick(2);
      get(2); c0 = gc;
      repeat (3) get(2);
      if (k == 767) chk("hue767", 64'(c0), 32'h00FFFF00);
      if (k == 768) chk("hue768", 64'(c0), 32'h00FFFF00);
      if (k == 1534) chk("hue1534", 64'(c0), 32'h000100FF);
      if (k == 1535) chk("hue1535", 64'(c0), 32'h000000FF);
      if (k == 1536) chk("hue_wrap0", 64'(c0), 32'h000000FF);
      if (k == 1537) chk("hue_wrap1", 64'(c0), 32'h000001FF);
    end
    // asynchronous reset while drawing
    tick(2);
    get(2);
    @(negedge clk);
    chk("pre_arst_valid", 64'(ov[2]), 1);
    chk("pre_arst_obj", 64'(oo[2]), 1);
    arst = 1'b1;
    #1;
    chk("arst_valid", 64'(ov[2]), 0);
    chk("arst_busy", 64'(ob[2]), 0);
    chk("arst_x", 64'(ox[2]), 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    tick(2);
    get(2);
    chk("post_arst_xy", {32'(gx), 32'(gy)}, {32'd101, 32'd101});
    chk("post_arst_color", 64'(gc), 32'h000001FF);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
